// File: rtl/fetch_sequencer.sv
// fetch_sequencer: registered fetch control FSM (IMEM handshake, hazard stalls, branch redirect/squash); optional FETCH_PERF_CNT_EN perf counters
module fetch_sequencer #(
  parameter int IMEM_TIMEOUT = 15,
  parameter int SQUASH_SLOTS = 1,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ack,
  input  logic        hazard_stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic        stallF,
  output logic        isBranchTaken,
  output logic [31:0] branchPC,
  output logic        track,
  output logic        flushD,
  output logic        fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);
  typedef enum logic [2:0] {BOOT, FETCH, WAIT, REDIRECT, SQUASH, ERROR} state_t;
  localparam logic [7:0] TMO = 8'(IMEM_TIMEOUT);
  localparam logic [1:0] SQ  = 2'(SQUASH_SLOTS);
  state_t     state;
  logic [7:0] wait_cnt;
  logic [1:0] sq_cnt;
  logic       taken;
  assign taken = br_valid & br_taken;
  // FSM and registered control word; one-cycle pulses default low every edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= BOOT;
      imem_req      <= 1'b0;
      stallF        <= 1'b1;
      isBranchTaken <= 1'b0;
      branchPC      <= 32'h0;
      track         <= 1'b0;
      flushD        <= 1'b0;
      fetch_err     <= 1'b0;
      wait_cnt      <= 8'd0;
      sq_cnt        <= 2'd0;
    end else begin
      isBranchTaken <= 1'b0;
      track         <= 1'b0;
      flushD        <= 1'b0;
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          stallF   <= 1'b0;
        end
        FETCH:
          if (taken) begin
            state         <= REDIRECT;
            branchPC      <= br_target;
            isBranchTaken <= 1'b1;
            stallF        <= 1'b0;
          end else if (hazard_stall) stallF <= 1'b1;
          else if (!imem_ack) begin
            state    <= WAIT;
            stallF   <= 1'b1;
            wait_cnt <= 8'd1;
          end else stallF <= 1'b0;
        WAIT:
          if (taken) begin
            state         <= REDIRECT;
            branchPC      <= br_target;
            isBranchTaken <= 1'b1;
            stallF        <= 1'b0;
            wait_cnt      <= 8'd0;
          end else if (imem_ack) begin
            state    <= FETCH;
            stallF   <= 1'b0;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TMO) begin
            state     <= ERROR;
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
          end else wait_cnt <= wait_cnt + 8'd1;
        REDIRECT: begin
          state  <= SQUASH;
          sq_cnt <= SQ;
          flushD <= 1'b1;
          stallF <= 1'b0;
        end
        SQUASH:
          if (sq_cnt == 2'd1) begin
            state  <= FETCH;
            sq_cnt <= 2'd0;
            track  <= 1'b1;
          end else begin
            sq_cnt <= sq_cnt - 2'd1;
            flushD <= 1'b1;
          end
        ERROR: begin
          stallF   <= 1'b1;
          imem_req <= 1'b0;
        end
        default: state <= BOOT;
      endcase
    end
`ifdef FETCH_PERF_CNT_EN
  logic stall_hit;
  assign stall_hit = stallF & (state == FETCH || state == WAIT);
  // saturating counters of fetch stall cycles and redirects taken
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_hit && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (state == REDIRECT && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  logic        clk = 1'b0, reset = 1'b1;
  logic        imem_ack = 1'b1, hazard_stall = 1'b0, br_valid = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_req, stallF, isBranchTaken, track, flushD, fetch_err;
  logic [31:0] branchPC;
  logic [4:0]  ctl;
  int          checks = 0, fails = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif
  fetch_sequencer dut (
    .clk(clk), .reset(reset), .imem_ack(imem_ack), .hazard_stall(hazard_stall),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .stallF(stallF), .isBranchTaken(isBranchTaken),
    .branchPC(branchPC), .track(track), .flushD(flushD), .fetch_err(fetch_err)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  assign ctl = {stallF, isBranchTaken, track, flushD, fetch_err};
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    tick;
    tick;
    checks++; if (ctl !== 5'b10000 || imem_req !== 1'b0) begin fails++; $display("FAIL reset_outs got ctl=%b req=%b exp ctl=10000 req=0", ctl, imem_req); end
    checks++; if (branchPC !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", branchPC); end
    reset = 1'b0;
    checks++; if (ctl !== 5'b10000 || imem_req !== 1'b0) begin fails++; $display("FAIL boot_bubble got ctl=%b req=%b exp ctl=10000 req=0", ctl, imem_req); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (ctl !== 5'b00000 || imem_req !== 1'b1) begin fails++; $display("FAIL fetch_run%0d got ctl=%b req=%b exp ctl=00000 req=1", i, ctl, imem_req); end
    end
  endtask
  task automatic test_redirect;
    br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h40;
    tick;
    br_valid = 1'b0; br_taken = 1'b0;
    checks++; if (ctl !== 5'b01000 || branchPC !== 32'h40) begin fails++; $display("FAIL redirect got ctl=%b pc=%h exp ctl=01000 pc=00000040", ctl, branchPC); end
    tick;
    checks++; if (ctl !== 5'b00010) begin fails++; $display("FAIL squash got ctl=%b exp 00010", ctl); end
    tick;
    checks++; if (ctl !== 5'b00100 || imem_req !== 1'b1) begin fails++; $display("FAIL track got ctl=%b req=%b exp ctl=00100 req=1", ctl, imem_req); end
    tick;
    checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL post_track got ctl=%b exp 00000", ctl); end
    br_valid = 1'b1; br_target = 32'h80;
    tick;
    br_valid = 1'b0;
    checks++; if (ctl !== 5'b00000 || branchPC !== 32'h40) begin fails++; $display("FAIL not_taken got ctl=%b pc=%h exp ctl=00000 pc=00000040", ctl, branchPC); end
  endtask
  task automatic test_hazard;
    hazard_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (ctl !== 5'b10000 || imem_req !== 1'b1) begin fails++; $display("FAIL hazard%0d got ctl=%b req=%b exp ctl=10000 req=1", i, ctl, imem_req); end
    end
    hazard_stall = 1'b0;
    tick;
    checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL hazard_release got ctl=%b exp 00000", ctl); end
  endtask
  task automatic test_wait;
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (ctl !== 5'b10000 || imem_req !== 1'b1) begin fails++; $display("FAIL wait%0d got ctl=%b req=%b exp ctl=10000 req=1", i, ctl, imem_req); end
    end
    imem_ack = 1'b1;
    tick;
    checks++; if (ctl !== 5'b00000 || imem_req !== 1'b1) begin fails++; $display("FAIL wait_resume got ctl=%b req=%b exp ctl=00000 req=1", ctl, imem_req); end
  endtask
  task automatic test_priority;
    hazard_stall = 1'b1; imem_ack = 1'b0; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h100;
    tick;
    imem_ack = 1'b1; br_target = 32'h200;
    checks++; if (ctl !== 5'b01000 || branchPC !== 32'h100) begin fails++; $display("FAIL prio_redirect got ctl=%b pc=%h exp ctl=01000 pc=00000100", ctl, branchPC); end
    tick;
    hazard_stall = 1'b0;
    checks++; if (ctl !== 5'b00010) begin fails++; $display("FAIL prio_squash got ctl=%b exp 00010", ctl); end
    tick;
    br_valid = 1'b0; br_taken = 1'b0;
    checks++; if (ctl !== 5'b00100 || branchPC !== 32'h100) begin fails++; $display("FAIL squash_ignore_br got ctl=%b pc=%h exp ctl=00100 pc=00000100", ctl, branchPC); end
    tick;
    checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL prio_resume got ctl=%b exp 00000", ctl); end
  endtask
  task automatic test_timeout;
    imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      checks++; if (ctl !== 5'b10000 || imem_req !== 1'b1) begin fails++; $display("FAIL timeout_wait%0d got ctl=%b req=%b exp ctl=10000 req=1", i, ctl, imem_req); end
    end
    tick;
    checks++; if (ctl !== 5'b10001 || imem_req !== 1'b0) begin fails++; $display("FAIL timeout_err got ctl=%b req=%b exp ctl=10001 req=0", ctl, imem_req); end
    imem_ack = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (ctl !== 5'b10001 || imem_req !== 1'b0 || branchPC !== 32'h100) begin fails++; $display("FAIL err_sticky%0d got ctl=%b req=%b pc=%h exp ctl=10001 req=0 pc=00000100", i, ctl, imem_req, branchPC); end
    end
    br_valid = 1'b0; br_taken = 1'b0;
  endtask
  task automatic test_async_reset;
    reset = 1'b1;
    tick;
    checks++; if (ctl !== 5'b10000 || imem_req !== 1'b0) begin fails++; $display("FAIL err_cleared got ctl=%b req=%b exp ctl=10000 req=0", ctl, imem_req); end
    reset = 1'b0;
    tick;
    br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h40;
    tick;
    br_valid = 1'b0; br_taken = 1'b0;
    tick;
    checks++; if (ctl !== 5'b00010) begin fails++; $display("FAIL pre_reset_squash got ctl=%b exp 00010", ctl); end
    #2 reset = 1'b1;
    #1;
    checks++; if (ctl !== 5'b10000 || imem_req !== 1'b0 || branchPC !== 32'h0) begin fails++; $display("FAIL async_reset got ctl=%b req=%b pc=%h exp ctl=10000 req=0 pc=0", ctl, imem_req, branchPC); end
    #1 reset = 1'b0;
    checks++; if (ctl !== 5'b10000 || imem_req !== 1'b0) begin fails++; $display("FAIL reboot_bubble got ctl=%b req=%b exp ctl=10000 req=0", ctl, imem_req); end
    tick;
    checks++; if (ctl !== 5'b00000 || imem_req !== 1'b1) begin fails++; $display("FAIL reboot_fetch got ctl=%b req=%b exp ctl=00000 req=1", ctl, imem_req); end
  endtask
  initial begin
    test_reset;
    test_redirect;
    test_hazard;
    test_wait;
    test_priority;
    test_timeout;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got no completion exp finish before 100000");
    $fatal(1);
  end
endmodule
